// File: rtl/wb_retire_stage_pkg.sv
// Shared types and helpers for the writeback / retire stage.
//   ld_size_e : load access size encoding carried on mem_ld_size
//   ptr_width : pointer width for a power-of-two queue depth (at least 1 bit)
package wb_retire_stage_pkg;

    typedef enum logic [1:0] {
        LD_B   = 2'b00,
        LD_H   = 2'b01,
        LD_W   = 2'b10,
        LD_RSV = 2'b11
    } ld_size_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load data formatter: selects byte/half/word lanes from the raw data-RAM
// word and sign- or zero-extends the result to XLEN.
//   rdata    in  raw data-RAM word
//   size     in  access size (ld_size_e encoding, reserved code acts as word)
//   uns      in  1 = zero-extend, 0 = sign-extend
//   offset   in  byte offset within the word
//   data     out formatted XLEN result
module wb_load_align
    import wb_retire_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      size,
    input  logic            uns,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection; halfword ignores offset[0]
    always_comb begin
        w_byte = rdata[7:0];
        case (offset)
            2'd0: w_byte = rdata[7:0];
            2'd1: w_byte = rdata[15:8];
            2'd2: w_byte = rdata[23:16];
            2'd3: w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
        w_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension to XLEN
    always_comb begin
        data = rdata;
        case (ld_size_e'(size))
            LD_B: data = {{(XLEN-8){w_byte[7] & ~uns}}, w_byte};
            LD_H: data = {{(XLEN-16){w_half[15] & ~uns}}, w_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_retire_stage.sv
// Final pipeline stage: formats load data, holds completed instructions in an
// in-order retire queue until the register-file write port accepts them,
// answers two source-register queries from the queue and drives the debug trace.
//   mem_*      in  instruction handoff from MEM (transfer = mem_valid & mem_ready)
//   rf_*       out register-file write request, rf_ready in accepts it
//   q_*        ID source-register queries (youngest pending match wins)
//   occupancy  out number of valid queue entries
//   debug_wb_* out retirement trace, valid only in the pop cycle
module wb_retire_stage
    import wb_retire_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RF_AW = 5,
    parameter int unsigned DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [31:0]               mem_pc,
    input  logic                      mem_rf_we,
    input  logic [RF_AW-1:0]          mem_rf_waddr,
    input  logic [XLEN-1:0]           mem_alu_result,
    input  logic                      mem_is_load,
    input  logic [1:0]                mem_ld_size,
    input  logic                      mem_ld_unsigned,
    input  logic [1:0]                mem_ld_offset,
    input  logic [XLEN-1:0]           mem_rdata,
    output logic                      rf_we,
    output logic [RF_AW-1:0]          rf_waddr,
    output logic [XLEN-1:0]           rf_wdata,
    input  logic                      rf_ready,
    input  logic [RF_AW-1:0]          q_raddr1,
    input  logic [RF_AW-1:0]          q_raddr2,
    output logic                      q_hit1,
    output logic                      q_hit2,
    output logic [XLEN-1:0]           q_data1,
    output logic [XLEN-1:0]           q_data2,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [31:0]               debug_wb_pc,
    output logic [3:0]                debug_wb_rf_wen,
    output logic [RF_AW-1:0]          debug_wb_rf_wnum,
    output logic [XLEN-1:0]           debug_wb_rf_wdata
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]      r_pc    [DEPTH];
    logic [RF_AW-1:0] r_waddr [DEPTH];
    logic [XLEN-1:0]  r_wdata [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_we;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_run;

    logic [XLEN-1:0]  w_ld_data;
    logic [XLEN-1:0]  w_in_data;
    logic             w_in_we;
    logic             w_head_vld;
    logic             w_head_we;
    logic             w_pop;
    logic             w_push;
    logic [PW-1:0]    w_q_idx;

    wb_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata  (mem_rdata),
        .size   (mem_ld_size),
        .uns    (mem_ld_unsigned),
        .offset (mem_ld_offset),
        .data   (w_ld_data)
    );

    assign w_in_data  = mem_is_load ? w_ld_data : mem_alu_result;
    // x0 is never written, so it is stored as a non-writing entry
    assign w_in_we    = mem_rf_we & (mem_rf_waddr != RF_AW'(0));

    assign w_head_vld = r_vld[r_head];
    assign w_head_we  = r_we[r_head];
    assign w_pop      = w_head_vld & (~w_head_we | rf_ready);
    // r_run keeps mem_ready low while reset is held
    assign mem_ready  = r_run & ((r_count < CW'(DEPTH)) | w_pop);
    assign w_push     = mem_valid & mem_ready;

    // Queue control; pop clears before push sets so a full pop+push keeps the slot valid
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vld   <= '0;
            r_we    <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PW'(1);
            end
            if (w_push) begin
                r_vld[r_tail] <= 1'b1;
                r_we[r_tail]  <= w_in_we;
                r_tail        <= r_tail + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Entry payload; qualified by r_vld so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_tail]    <= mem_pc;
            r_waddr[r_tail] <= mem_rf_waddr;
            r_wdata[r_tail] <= w_in_data;
        end
    end

    assign rf_we     = w_head_vld & w_head_we;
    assign rf_waddr  = w_head_vld ? r_waddr[r_head] : RF_AW'(0);
    assign rf_wdata  = w_head_vld ? r_wdata[r_head] : XLEN'(0);
    assign occupancy = r_count;

    assign debug_wb_pc       = w_pop ? r_pc[r_head] : 32'd0;
    assign debug_wb_rf_wen   = (w_pop & w_head_we) ? 4'hF : 4'h0;
    assign debug_wb_rf_wnum  = w_pop ? r_waddr[r_head] : RF_AW'(0);
    assign debug_wb_rf_wdata = w_pop ? r_wdata[r_head] : XLEN'(0);

    // Walk oldest to youngest so the last match (youngest) wins
    always_comb begin
        q_hit1  = 1'b0;
        q_hit2  = 1'b0;
        q_data1 = '0;
        q_data2 = '0;
        w_q_idx = r_head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_q_idx = r_head + PW'(i);
            if (r_vld[w_q_idx] && r_we[w_q_idx] && (r_waddr[w_q_idx] == q_raddr1)) begin
                q_hit1  = 1'b1;
                q_data1 = r_wdata[w_q_idx];
            end
            if (r_vld[w_q_idx] && r_we[w_q_idx] && (r_waddr[w_q_idx] == q_raddr2)) begin
                q_hit2  = 1'b1;
                q_data2 = r_wdata[w_q_idx];
            end
        end
    end

endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed self-checking bench for wb_retire_stage (XLEN=32, RF_AW=5, DEPTH=2).
module tb_wb_retire_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_pc;
    logic        mem_rf_we;
    logic [4:0]  mem_rf_waddr;
    logic [31:0] mem_alu_result;
    logic        mem_is_load;
    logic [1:0]  mem_ld_size;
    logic        mem_ld_unsigned;
    logic [1:0]  mem_ld_offset;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_ready;
    logic [4:0]  q_raddr1;
    logic [4:0]  q_raddr2;
    logic        q_hit1;
    logic        q_hit2;
    logic [31:0] q_data1;
    logic [31:0] q_data2;
    logic [1:0]  occupancy;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    wb_retire_stage #(.XLEN(32), .RF_AW(5), .DEPTH(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .mem_pc            (mem_pc),
        .mem_rf_we         (mem_rf_we),
        .mem_rf_waddr      (mem_rf_waddr),
        .mem_alu_result    (mem_alu_result),
        .mem_is_load       (mem_is_load),
        .mem_ld_size       (mem_ld_size),
        .mem_ld_unsigned   (mem_ld_unsigned),
        .mem_ld_offset     (mem_ld_offset),
        .mem_rdata         (mem_rdata),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .rf_ready          (rf_ready),
        .q_raddr1          (q_raddr1),
        .q_raddr2          (q_raddr2),
        .q_hit1            (q_hit1),
        .q_hit2            (q_hit2),
        .q_data1           (q_data1),
        .q_data2           (q_data2),
        .occupancy         (occupancy),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid       = 1'b0;
        mem_pc          = 32'd0;
        mem_rf_we       = 1'b0;
        mem_rf_waddr    = 5'd0;
        mem_alu_result  = 32'd0;
        mem_is_load     = 1'b0;
        mem_ld_size     = 2'b10;
        mem_ld_unsigned = 1'b0;
        mem_ld_offset   = 2'd0;
        mem_rdata       = 32'd0;
    endtask

    task automatic drive_alu(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                             input logic [31:0] val);
        mem_valid      = 1'b1;
        mem_pc         = pc;
        mem_rf_we      = we;
        mem_rf_waddr   = wa;
        mem_alu_result = val;
        mem_is_load    = 1'b0;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        rf_ready  = 1'b1;
        q_raddr1  = 5'd0;
        q_raddr2  = 5'd0;
        idle_inputs();
        drive_alu(32'h0000_0040, 1'b1, 5'd3, 32'h1234_5678);
        step();
        step();
        n_tests++;
        if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready got %b want 0", mem_ready); end
        n_tests++;
        if ({rf_we, rf_waddr, rf_wdata, occupancy} !== 40'd0) begin
            n_fail++; $display("FAIL reset_rf got we=%b wa=%0d wd=%h occ=%0d want all 0", rf_we, rf_waddr, rf_wdata, occupancy);
        end
        n_tests++;
        if ({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, q_hit1, q_hit2} !== 75'd0) begin
            n_fail++; $display("FAIL reset_debug got pc=%h wen=%h wnum=%0d wd=%h want all 0", debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
        end
        idle_inputs();
        resetn = 1'b1;
        step();
        n_tests++;
        if (mem_ready !== 1'b1 || occupancy !== 2'd0) begin
            n_fail++; $display("FAIL reset_release got ready=%b occ=%0d want 1/0", mem_ready, occupancy);
        end
    endtask

    task automatic test_load_format();
        logic [1:0]  sz  [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b10};
        logic        un  [10] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
        logic [1:0]  off [10] = '{2'd2,  2'd2,  2'd1,  2'd3,  2'd2,  2'd3,  2'd0,  2'd1,  2'd0,  2'd0};
        logic        ld  [10] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
        logic [31:0] exp [10] = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'h0000_007F, 32'hFFFF_FF80,
                                  32'hFFFF_80F1, 32'h0000_80F1, 32'h0000_7F05, 32'h80F1_7F05,
                                  32'h80F1_7F05, 32'hDEAD_BEEF};
        rf_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_alu(32'h0000_1000 + 32'(i * 4), 1'b1, 5'(i + 1), 32'hDEAD_BEEF);
            mem_is_load     = ld[i];
            mem_ld_size     = sz[i];
            mem_ld_unsigned = un[i];
            mem_ld_offset   = off[i];
            mem_rdata       = 32'h80F1_7F05;
            step();
            idle_inputs();
            n_tests++;
            if (rf_we !== 1'b1 || rf_wdata !== exp[i] || debug_wb_rf_wdata !== exp[i] || debug_wb_rf_wen !== 4'hF) begin
                n_fail++;
                $display("FAIL load_fmt[%0d] got we=%b wd=%h dbg=%h wen=%h want 1/%h/%h/F", i, rf_we, rf_wdata, debug_wb_rf_wdata, debug_wb_rf_wen, exp[i], exp[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        rf_ready = 1'b0;
        drive_alu(32'h0000_0100, 1'b1, 5'd1, 32'h0000_00A1);
        step();
        drive_alu(32'h0000_0104, 1'b1, 5'd2, 32'h0000_00B2);
        step();
        drive_alu(32'h0000_0108, 1'b1, 5'd3, 32'h0000_00C3);
        #1;
        n_tests++;
        if (mem_ready !== 1'b0 || occupancy !== 2'd2 || rf_we !== 1'b1 || rf_waddr !== 5'd1 || debug_wb_pc !== 32'd0) begin
            n_fail++; $display("FAIL bp_full got ready=%b occ=%0d we=%b wa=%0d dpc=%h want 0/2/1/1/0", mem_ready, occupancy, rf_we, rf_waddr, debug_wb_pc);
        end
        step();
        rf_ready = 1'b1;
        #1;
        n_tests++;
        if (occupancy !== 2'd2 || mem_ready !== 1'b1 || rf_wdata !== 32'hA1 || debug_wb_pc !== 32'h100) begin
            n_fail++; $display("FAIL bp_pop_push got occ=%0d ready=%b wd=%h dpc=%h want 2/1/a1/100", occupancy, mem_ready, rf_wdata, debug_wb_pc);
        end
        step();
        idle_inputs();
        n_tests++;
        if (occupancy !== 2'd2 || rf_wdata !== 32'hB2 || rf_waddr !== 5'd2 || debug_wb_rf_wnum !== 5'd2 || debug_wb_pc !== 32'h104) begin
            n_fail++; $display("FAIL bp_second got occ=%0d wd=%h wa=%0d wnum=%0d dpc=%h want 2/b2/2/2/104", occupancy, rf_wdata, rf_waddr, debug_wb_rf_wnum, debug_wb_pc);
        end
        step();
        n_tests++;
        if (occupancy !== 2'd1 || rf_wdata !== 32'hC3 || rf_waddr !== 5'd3 || debug_wb_pc !== 32'h108) begin
            n_fail++; $display("FAIL bp_third got occ=%0d wd=%h wa=%0d dpc=%h want 1/c3/3/108", occupancy, rf_wdata, rf_waddr, debug_wb_pc);
        end
        step();
        n_tests++;
        if (occupancy !== 2'd0 || rf_we !== 1'b0 || debug_wb_pc !== 32'd0) begin
            n_fail++; $display("FAIL bp_drained got occ=%0d we=%b dpc=%h want 0/0/0", occupancy, rf_we, debug_wb_pc);
        end
    endtask

    task automatic test_query_priority();
        rf_ready = 1'b0;
        q_raddr1 = 5'd5;
        q_raddr2 = 5'd0;
        drive_alu(32'h0000_0200, 1'b1, 5'd5, 32'h0000_0011);
        step();
        drive_alu(32'h0000_0204, 1'b1, 5'd5, 32'h0000_0022);
        #1;
        n_tests++;
        if (q_hit1 !== 1'b1 || q_data1 !== 32'h11) begin
            n_fail++; $display("FAIL q_push_invisible got hit=%b data=%h want 1/11", q_hit1, q_data1);
        end
        step();
        idle_inputs();
        n_tests++;
        if (q_hit1 !== 1'b1 || q_data1 !== 32'h22 || q_hit2 !== 1'b0 || q_data2 !== 32'd0) begin
            n_fail++; $display("FAIL q_youngest got hit1=%b d1=%h hit2=%b d2=%h want 1/22/0/0", q_hit1, q_data1, q_hit2, q_data2);
        end
        q_raddr2 = 5'd7;
        #1;
        n_tests++;
        if (q_hit2 !== 1'b0 || q_data2 !== 32'd0) begin
            n_fail++; $display("FAIL q_miss got hit=%b data=%h want 0/0", q_hit2, q_data2);
        end
        rf_ready = 1'b1;
        step();
        n_tests++;
        if (q_hit1 !== 1'b1 || q_data1 !== 32'h22 || rf_we !== 1'b1) begin
            n_fail++; $display("FAIL q_popping_visible got hit=%b data=%h we=%b want 1/22/1", q_hit1, q_data1, rf_we);
        end
        step();
        n_tests++;
        if (q_hit1 !== 1'b0 || q_data1 !== 32'd0) begin
            n_fail++; $display("FAIL q_empty got hit=%b data=%h want 0/0", q_hit1, q_data1);
        end
        rf_ready = 1'b0;
        q_raddr2 = 5'd0;
        drive_alu(32'h0000_0208, 1'b1, 5'd0, 32'h0000_0055);
        step();
        idle_inputs();
        n_tests++;
        if (q_hit2 !== 1'b0 || q_data2 !== 32'd0 || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL q_x0 got hit=%b data=%h we=%b want 0/0/0", q_hit2, q_data2, rf_we);
        end
        step();
    endtask

    task automatic test_nonwriting();
        rf_ready = 1'b0;
        drive_alu(32'h0000_0300, 1'b0, 5'd9, 32'h0000_0099);
        step();
        idle_inputs();
        n_tests++;
        if (rf_we !== 1'b0 || debug_wb_pc !== 32'h300 || debug_wb_rf_wen !== 4'h0 || occupancy !== 2'd1) begin
            n_fail++; $display("FAIL nw_we0 got we=%b dpc=%h wen=%h occ=%0d want 0/300/0/1", rf_we, debug_wb_pc, debug_wb_rf_wen, occupancy);
        end
        step();
        n_tests++;
        if (occupancy !== 2'd0 || debug_wb_pc !== 32'd0) begin
            n_fail++; $display("FAIL nw_retired got occ=%0d dpc=%h want 0/0", occupancy, debug_wb_pc);
        end
        drive_alu(32'h0000_0304, 1'b1, 5'd0, 32'h0000_0077);
        step();
        idle_inputs();
        n_tests++;
        if (rf_we !== 1'b0 || debug_wb_pc !== 32'h304 || debug_wb_rf_wen !== 4'h0) begin
            n_fail++; $display("FAIL nw_x0 got we=%b dpc=%h wen=%h want 0/304/0", rf_we, debug_wb_pc, debug_wb_rf_wen);
        end
        step();
    endtask

    task automatic test_back_to_back_wrap();
        rf_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_alu(32'h0000_0400 + 32'(k * 4), 1'b1, 5'(k + 10), 32'h0000_1000 + 32'(k));
            step();
            n_tests++;
            if (rf_we !== 1'b1 || rf_wdata !== 32'h0000_1000 + 32'(k) || rf_waddr !== 5'(k + 10)
                || occupancy !== 2'd1 || mem_ready !== 1'b1) begin
                n_fail++; $display("FAIL wrap[%0d] got we=%b wd=%h wa=%0d occ=%0d ready=%b", k, rf_we, rf_wdata, rf_waddr, occupancy, mem_ready);
            end
        end
        idle_inputs();
        step();
        n_tests++;
        if (occupancy !== 2'd0 || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL wrap_drain got occ=%0d we=%b want 0/0", occupancy, rf_we);
        end
    endtask

    task automatic test_async_reset();
        rf_ready = 1'b0;
        drive_alu(32'h0000_0500, 1'b1, 5'd4, 32'h0000_0044);
        step();
        drive_alu(32'h0000_0504, 1'b1, 5'd6, 32'h0000_0066);
        step();
        idle_inputs();
        n_tests++;
        if (occupancy !== 2'd2 || rf_we !== 1'b1) begin
            n_fail++; $display("FAIL ar_pre got occ=%0d we=%b want 2/1", occupancy, rf_we);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (rf_we !== 1'b0 || occupancy !== 2'd0 || mem_ready !== 1'b0 || rf_wdata !== 32'd0) begin
            n_fail++; $display("FAIL ar_immediate got we=%b occ=%0d ready=%b wd=%h want 0/0/0/0", rf_we, occupancy, mem_ready, rf_wdata);
        end
        rf_ready = 1'b1;
        step();
        resetn = 1'b1;
        step();
        step();
        n_tests++;
        if (rf_we !== 1'b0 || occupancy !== 2'd0 || mem_ready !== 1'b1 || debug_wb_pc !== 32'd0) begin
            n_fail++; $display("FAIL ar_after got we=%b occ=%0d ready=%b dpc=%h want 0/0/1/0", rf_we, occupancy, mem_ready, debug_wb_pc);
        end
    endtask

    initial begin
        test_reset();
        test_load_format();
        test_backpressure();
        test_query_priority();
        test_nonwriting();
        test_back_to_back_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
